// File: rtl/fft_stage_scheduler.sv
// In-place radix-2 DIT FFT scheduler: issues butterfly read/twiddle addresses
// stage by stage, then replays the addresses as write-backs LAT cycles later.
module fft_stage_scheduler #(
  parameter int unsigned LOG2_N       = 5,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned PIPE_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [LOG2_N-1:0]       rd_addr_a,
  output logic [LOG2_N-1:0]       rd_addr_b,
  output logic [LOG2_N-2:0]       tw_addr,
  output logic                    wr_en,
  output logic [LOG2_N-1:0]       wr_addr_a,
  output logic [LOG2_N-1:0]       wr_addr_b,
  output logic [((LOG2_N > 1) ? $clog2(LOG2_N) : 1)-1:0] stage
);

  localparam int unsigned LAT  = RD_LATENCY + PIPE_LATENCY;
  localparam int unsigned HALF = 32'd1 << (LOG2_N - 1);
  localparam int unsigned KW   = LOG2_N - 1;
  localparam int unsigned SW   = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;
  localparam int unsigned WW   = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t          state, state_n;
  logic [KW-1:0]   k, k_n;
  logic [SW-1:0]   stage_n;
  logic [WW-1:0]   wcnt, wcnt_n;

  logic [31:0]       sh;
  logic [LOG2_N-1:0] kx, span, pos, addr_a, addr_b;
  logic [KW-1:0]     tw;

  logic [LAT-1:0]             dl_en;
  logic [LAT-1:0][LOG2_N-1:0] dl_a;
  logic [LAT-1:0][LOG2_N-1:0] dl_b;

  // Next-state, butterfly counter, stage and wait-counter logic
  always_comb begin
    state_n = state;
    k_n     = k;
    stage_n = stage;
    wcnt_n  = wcnt;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_ISSUE;
          k_n     = '0;
          stage_n = '0;
        end
      end
      S_ISSUE: begin
        if (k == KW'(HALF - 1)) begin
          state_n = S_WAIT;
          wcnt_n  = '0;
        end else begin
          k_n = k + KW'(1);
        end
      end
      S_WAIT: begin
        // Hold off reads until the stage's last write-back has landed
        if (wcnt == WW'(LAT - 1)) begin
          if (stage < SW'(LOG2_N - 1)) begin
            state_n = S_ISSUE;
            stage_n = stage + SW'(1);
            k_n     = '0;
          end else begin
            state_n = S_FIN;
          end
        end else begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      S_FIN: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Butterfly addresses for the upcoming stage/k pair
  always_comb begin
    sh     = 32'(stage_n);
    kx     = LOG2_N'(k_n);
    span   = LOG2_N'(1) << sh;
    pos    = kx & (span - LOG2_N'(1));
    addr_a = ((kx >> sh) << (sh + 32'd1)) | pos;
    addr_b = addr_a + span;
    tw     = KW'(pos << (32'(LOG2_N) - 32'd1 - sh));
  end

  // State register and registered issue-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= '0;
      stage     <= '0;
      wcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      stage     <= stage_n;
      wcnt      <= wcnt_n;
      busy      <= (state_n == S_ISSUE) || (state_n == S_WAIT);
      done      <= (state_n == S_FIN);
      rd_en     <= (state_n == S_ISSUE);
      rd_addr_a <= (state_n == S_ISSUE) ? addr_a : '0;
      rd_addr_b <= (state_n == S_ISSUE) ? addr_b : '0;
      tw_addr   <= (state_n == S_ISSUE) ? tw : '0;
    end
  end

  // LAT-deep delay line turning each read issue into its write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_en <= '0;
      dl_a  <= '0;
      dl_b  <= '0;
    end else begin
      dl_en[0] <= rd_en;
      dl_a[0]  <= rd_addr_a;
      dl_b[0]  <= rd_addr_b;
      for (int i = 1; i < LAT; i++) begin
        dl_en[i] <= dl_en[i-1];
        dl_a[i]  <= dl_a[i-1];
        dl_b[i]  <= dl_b[i-1];
      end
    end
  end

  assign wr_en     = dl_en[LAT-1];
  assign wr_addr_a = dl_a[LAT-1];
  assign wr_addr_b = dl_b[LAT-1];

endmodule
